hex_display_scheduler: RTL and testbench

//  Decides what the four seven_segment digit inputs show in the Mastermind game.

---
 rtl/hex_display_if.sv | 27 ++
 rtl/hex_display_scheduler.sv | 122 ++++++++++++
 tb/tb_hex_display_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_if.sv
// Display-scheduler bundle: game FSM requests and data in, seven-segment digit codes out.
// Master is the game side. Slave is the scheduler.
interface hex_display_if;
    logic        new_game;
    logic [11:0] guess;
    logic        fb_req;
    logic [2:0]  fb_black;
    logic [2:0]  fb_white;
    logic        reveal_req;
    logic [11:0] secret;
    logic [2:0]  d0;
    logic [2:0]  d1;
    logic [2:0]  d2;
    logic [2:0]  d3;
    logic [1:0]  mode;
    logic        busy;

    modport master (
        output new_game, guess, fb_req, fb_black, fb_white, reveal_req, secret,
        input  d0, d1, d2, d3, mode, busy
    );

    modport slave (
        input  new_game, guess, fb_req, fb_black, fb_white, reveal_req, secret,
        output d0, d1, d2, d3, mode, busy
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Chooses the digits shown: live guess, timed peg feedback, or blinking secret reveal.
// Latency: one cycle from a sampled request or guess to registered digits, mode and busy.
// Backpressure: none. fb_req is dropped while revealing; new_game and reveal_req always win.
module hex_display_scheduler #(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int BLINK_COUNT  = 4,
    parameter int CNT_W        = 27
) (
    input logic         clk,
    input logic         rst_n,
    hex_display_if.slave bus
);
    typedef enum logic [1:0] {
        GUESS      = 2'b00,
        FEEDBACK   = 2'b01,
        REVEAL_ON  = 2'b10,
        REVEAL_OFF = 2'b11
    } mode_t;

    localparam int BW = $clog2(BLINK_COUNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [BW-1:0]    BLINK_MAX  = BW'(BLINK_COUNT);
    localparam logic [11:0]      DASHES     = 12'o7777;

    mode_t             state;
    logic [CNT_W-1:0]  timer;
    logic [BW-1:0]     blinks;
    logic [2:0]        black_q;
    logic [2:0]        white_q;
    logic [11:0]       secret_q;
    logic [11:0]       disp;
    logic              busy_q;
    logic              fb_ok;

    assign fb_ok = (state == GUESS) || (state == FEEDBACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= GUESS;
            timer    <= '0;
            blinks   <= '0;
            black_q  <= '0;
            white_q  <= '0;
            secret_q <= '0;
            disp     <= DASHES;
            busy_q   <= 1'b0;
        end else if (bus.new_game) begin
            state  <= GUESS;
            timer  <= '0;
            blinks <= '0;
            disp   <= bus.guess;
            busy_q <= 1'b0;
        end else if (bus.reveal_req) begin
            state    <= REVEAL_ON;
            timer    <= '0;
            blinks   <= BW'(1);
            secret_q <= bus.secret;
            disp     <= bus.secret;
            busy_q   <= 1'b1;
        end else if (bus.fb_req && fb_ok) begin
            state   <= FEEDBACK;
            timer   <= '0;
            black_q <= bus.fb_black;
            white_q <= bus.fb_white;
            disp    <= {bus.fb_black, 3'd7, 3'd7, bus.fb_white};
            busy_q  <= 1'b1;
        end else begin
            // The timer is cleared on every transition, so it never needs to wrap.
            unique case (state)
                GUESS: begin
                    disp <= bus.guess;
                end
                FEEDBACK: begin
                    if (timer == HOLD_LAST) begin
                        state  <= GUESS;
                        timer  <= '0;
                        disp   <= bus.guess;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                        disp  <= {black_q, 3'd7, 3'd7, white_q};
                    end
                end
                REVEAL_ON: begin
                    if (timer != BLINK_LAST) begin
                        timer <= timer + 1'b1;
                    end else if (blinks == BLINK_MAX) begin
                        state  <= GUESS;
                        timer  <= '0;
                        blinks <= '0;
                        disp   <= bus.guess;
                        busy_q <= 1'b0;
                    end else begin
                        state <= REVEAL_OFF;
                        timer <= '0;
                        disp  <= DASHES;
                    end
                end
                REVEAL_OFF: begin
                    if (timer == BLINK_LAST) begin
                        state  <= REVEAL_ON;
                        timer  <= '0;
                        blinks <= (blinks == BLINK_MAX) ? blinks : blinks + BW'(1);
                        disp   <= secret_q;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= GUESS;
            endcase
        end
    end

    assign bus.d0   = disp[2:0];
    assign bus.d1   = disp[5:3];
    assign bus.d2   = disp[8:6];
    assign bus.d3   = disp[11:9];
    assign bus.mode = state;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with a frame-queue display model checked every cycle.
module tb_hex_display_scheduler;
    localparam int HOLD  = 5;
    localparam int BLINK = 3;
    localparam int BCNT  = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    hex_display_if ifc ();

    hex_display_scheduler #(
        .HOLD_CYCLES (HOLD),
        .BLINK_CYCLES(BLINK),
        .BLINK_COUNT (BCNT),
        .CNT_W       (27)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    logic [11:0] dout;
    assign dout = {ifc.d3, ifc.d2, ifc.d1, ifc.d0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted request queues the exact sequence of frames it will show.
    typedef struct packed {
        logic [11:0] d;
        logic [1:0]  m;
    } frame_t;

    frame_t      q[$];
    frame_t      f;
    bit          in_rev = 1'b0;
    logic [11:0] exp_d  = 12'o7777;
    logic [1:0]  exp_m  = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            in_rev = 1'b0;
            exp_d  = 12'o7777;
            exp_m  = 2'b00;
        end else begin
            if (ifc.new_game) begin
                q.delete();
                in_rev = 1'b0;
            end else if (ifc.reveal_req) begin
                q.delete();
                for (int k = 1; k <= BCNT; k++) begin
                    for (int t = 0; t < BLINK; t++) q.push_back('{ifc.secret, 2'b10});
                    if (k < BCNT)
                        for (int t = 0; t < BLINK; t++) q.push_back('{12'o7777, 2'b11});
                end
                in_rev = 1'b1;
            end else if (ifc.fb_req && !in_rev) begin
                q.delete();
                for (int t = 0; t < HOLD; t++)
                    q.push_back('{{ifc.fb_black, 3'd7, 3'd7, ifc.fb_white}, 2'b01});
            end
            if (q.size() > 0) begin
                f     = q.pop_front();
                exp_d = f.d;
                exp_m = f.m;
            end else begin
                in_rev = 1'b0;
                exp_d  = ifc.guess;
                exp_m  = 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_d", 32'(dout), 32'(exp_d));
        chk("model_mode", 32'(ifc.mode), 32'(exp_m));
        chk("model_busy", 32'(ifc.busy), 32'(exp_m != 2'b00));
    end

    task automatic pulse_fb(input logic [2:0] b, input logic [2:0] w);
        ifc.fb_req   = 1'b1;
        ifc.fb_black = b;
        ifc.fb_white = w;
        @(negedge clk);
        ifc.fb_req = 1'b0;
    endtask

    task automatic pulse_reveal(input logic [11:0] s);
        ifc.reveal_req = 1'b1;
        ifc.secret     = s;
        @(negedge clk);
        ifc.reveal_req = 1'b0;
    endtask

    task automatic fb_len(input string nm);
        int n = 0;
        while (ifc.mode == 2'b01 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, HOLD);
    endtask

    logic [11:0] prev_g;
    logic [11:0] want;

    initial begin
        rst_n          = 1'b0;
        ifc.new_game   = 1'b0;
        ifc.fb_req     = 1'b0;
        ifc.reveal_req = 1'b0;
        ifc.fb_black   = '0;
        ifc.fb_white   = '0;
        ifc.secret     = '0;
        ifc.guess      = 12'o5432;

        // Reset and release
        repeat (2) @(negedge clk);
        chk("rst_d", 32'(dout), 32'o7777);
        chk("rst_mode", 32'(ifc.mode), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_d", 32'(dout), 32'o5432);
        chk("rel_busy", 32'(ifc.busy), 0);

        // Single feedback
        pulse_fb(3'd2, 3'd1);
        chk("fb_disp", 32'(dout), 32'o2771);
        chk("fb_mode", 32'(ifc.mode), 1);
        fb_len("fb_len");
        chk("fb_back_d", 32'(dout), 32'o5432);
        chk("fb_back_mode", 32'(ifc.mode), 0);

        // Feedback restarted three cycles later
        pulse_fb(3'd1, 3'd3);
        chk("fb1_disp", 32'(dout), 32'o1773);
        repeat (2) @(negedge clk);
        pulse_fb(3'd4, 3'd0);
        chk("fb2_disp", 32'(dout), 32'o4770);
        fb_len("fb2_len");

        // Reveal with guess changing and an ignored fb_req
        pulse_reveal(12'o0135);
        prev_g = ifc.guess;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) want = prev_g;
            else if (i <= 3 || i >= 7) want = 12'o0135;
            else want = 12'o7777;
            chk("rev_seq", 32'(dout), 32'(want));
            prev_g    = 12'(12'o1230 + i);
            ifc.guess = prev_g;
            if (i == 4) begin
                ifc.fb_req   = 1'b1;
                ifc.fb_black = 3'd3;
                ifc.fb_white = 3'd3;
            end
            if (i == 5) ifc.fb_req = 1'b0;
            @(negedge clk);
        end
        chk("rev_end_mode", 32'(ifc.mode), 0);

        // Out-of-range peg counts pass through
        pulse_fb(3'd6, 3'd7);
        chk("fb_raw", 32'(dout), 32'o6777);
        repeat (6) @(negedge clk);

        // fb_req and reveal_req together, then new_game in REVEAL_OFF
        ifc.fb_req     = 1'b1;
        ifc.fb_black   = 3'd3;
        ifc.fb_white   = 3'd3;
        pulse_reveal(12'o7654);
        ifc.fb_req = 1'b0;
        chk("both_mode", 32'(ifc.mode), 2);
        chk("both_d", 32'(dout), 32'o7654);
        repeat (3) @(negedge clk);
        chk("off_mode", 32'(ifc.mode), 3);
        ifc.new_game = 1'b1;
        @(negedge clk);
        ifc.new_game = 1'b0;
        chk("ng_mode", 32'(ifc.mode), 0);
        chk("ng_d", 32'(dout), 32'(ifc.guess));

        // Reveal restarted mid-sequence
        pulse_reveal(12'o2222);
        repeat (2) @(negedge clk);
        pulse_reveal(12'o3333);
        chk("rerev_d", 32'(dout), 32'o3333);
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-feedback
        pulse_fb(3'd2, 3'd2);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d", 32'(dout), 32'o7777);
        chk("arst_mode", 32'(ifc.mode), 0);
        chk("arst_busy", 32'(ifc.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_d", 32'(dout), 32'(ifc.guess));
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
